// File: rtl/decode_stage.sv
// decode_stage: registered RV32/RV64 instruction decode with valid/ready handshake and optional skid buffer.
// Optional SYSTEM/CSR decode is compiled in when the DECODE_CSR_EN macro is defined.
module decode_stage #(
  parameter int XLEN = 32'd32,
  parameter int SKID = 32'd0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_rs1_en,
  output logic            out_rs2_en,
  output logic            out_rd_wen,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  localparam bit RV64 = (XLEN == 32'd64);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_SYS = 3'd6;
  localparam logic [2:0] FMT_BAD = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rs1_en;
    logic            rs2_en;
    logic            rd_wen;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } bundle_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic signed [XLEN-1:0] r;
    r = $signed(v);
    return r;
  endfunction

  logic [6:0] op_s;
  logic [2:0] f3_s;
  logic [6:0] f7_s;
  logic       bad_s;
  logic       wr_s;
  bundle_t    fld_s;
  bundle_t    dec_s;
  bundle_t    out_r;
  bundle_t    skid_r;
  logic       out_valid_r;
  logic       skid_valid_r;
  logic       out_free_s;
  logic       accept_s;

  assign op_s = in_instr[6:0];
  assign f3_s = in_instr[14:12];
  assign f7_s = in_instr[31:25];

  // Field extraction and legality per opcode; illegal words collapse to a zeroed BAD bundle.
  always_comb begin
    fld_s        = '0;
    fld_s.pc     = in_pc;
    fld_s.opcode = op_s;
    bad_s        = 1'b0;
    wr_s         = 1'b0;
    case (op_s)
      OP_R: begin
        fld_s.fmt    = FMT_R;
        fld_s.funct3 = f3_s;
        fld_s.funct7 = f7_s;
        fld_s.rs1    = in_instr[19:15];
        fld_s.rs2    = in_instr[24:20];
        fld_s.rd     = in_instr[11:7];
        fld_s.rs1_en = 1'b1;
        fld_s.rs2_en = 1'b1;
        wr_s         = 1'b1;
        if (f7_s == 7'b0000000) begin
          bad_s = 1'b0;
        end else if (f7_s == 7'b0100000) begin
          bad_s = !((f3_s == 3'b000) || (f3_s == 3'b101));
        end else begin
          bad_s = 1'b1;
        end
      end
      OP_IMM: begin
        fld_s.fmt    = FMT_I;
        fld_s.funct3 = f3_s;
        fld_s.rs1    = in_instr[19:15];
        fld_s.rd     = in_instr[11:7];
        fld_s.rs1_en = 1'b1;
        wr_s         = 1'b1;
        if ((f3_s == 3'b001) || (f3_s == 3'b101)) begin
          // instr[25] is shamt[5] on RV64, so it never belongs to the reported funct7
          fld_s.funct7 = {in_instr[31:26], 1'b0};
          fld_s.imm    = RV64 ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);
          if (!RV64 && in_instr[25]) begin
            bad_s = 1'b1;
          end else if (f3_s == 3'b001) begin
            bad_s = (in_instr[31:26] != 6'b000000);
          end else begin
            bad_s = !((in_instr[31:26] == 6'b000000) || (in_instr[31:26] == 6'b010000));
          end
        end else begin
          fld_s.imm = sext32({{20{in_instr[31]}}, in_instr[31:20]});
        end
      end
      OP_LOAD: begin
        fld_s.fmt    = FMT_I;
        fld_s.funct3 = f3_s;
        fld_s.rs1    = in_instr[19:15];
        fld_s.rd     = in_instr[11:7];
        fld_s.rs1_en = 1'b1;
        fld_s.imm    = sext32({{20{in_instr[31]}}, in_instr[31:20]});
        wr_s         = 1'b1;
        bad_s        = (f3_s == 3'b111) || (!RV64 && ((f3_s == 3'b011) || (f3_s == 3'b110)));
      end
      OP_STORE: begin
        fld_s.fmt    = FMT_S;
        fld_s.funct3 = f3_s;
        fld_s.rs1    = in_instr[19:15];
        fld_s.rs2    = in_instr[24:20];
        fld_s.rs1_en = 1'b1;
        fld_s.rs2_en = 1'b1;
        fld_s.imm    = sext32({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
        bad_s        = f3_s[2] || (!RV64 && (f3_s == 3'b011));
      end
      OP_BR: begin
        fld_s.fmt    = FMT_B;
        fld_s.funct3 = f3_s;
        fld_s.rs1    = in_instr[19:15];
        fld_s.rs2    = in_instr[24:20];
        fld_s.rs1_en = 1'b1;
        fld_s.rs2_en = 1'b1;
        fld_s.imm    = sext32({{19{in_instr[31]}}, in_instr[31], in_instr[7],
                               in_instr[30:25], in_instr[11:8], 1'b0});
        bad_s        = (f3_s == 3'b010) || (f3_s == 3'b011);
      end
      OP_JAL: begin
        fld_s.fmt = FMT_J;
        fld_s.rd  = in_instr[11:7];
        fld_s.imm = sext32({{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0});
        wr_s      = 1'b1;
      end
      OP_JALR: begin
        fld_s.fmt    = FMT_I;
        fld_s.funct3 = f3_s;
        fld_s.rs1    = in_instr[19:15];
        fld_s.rd     = in_instr[11:7];
        fld_s.rs1_en = 1'b1;
        fld_s.imm    = sext32({{20{in_instr[31]}}, in_instr[31:20]});
        wr_s         = 1'b1;
        bad_s        = (f3_s != 3'b000);
      end
      OP_LUI, OP_AUIPC: begin
        fld_s.fmt = FMT_U;
        fld_s.rd  = in_instr[11:7];
        fld_s.imm = sext32({in_instr[31:12], 12'h000});
        wr_s      = 1'b1;
      end
`ifdef DECODE_CSR_EN
      OP_SYS: begin
        // rs1 carries either the source register or the 5-bit zimm
        fld_s.fmt    = FMT_SYS;
        fld_s.funct3 = f3_s;
        fld_s.rs1    = in_instr[19:15];
        fld_s.rd     = in_instr[11:7];
        fld_s.imm    = XLEN'(in_instr[31:20]);
        fld_s.rs1_en = !f3_s[2] && (f3_s != 3'b000);
        wr_s         = 1'b1;
        case (f3_s)
          3'b000:  bad_s = !((in_instr == 32'h0000_0073) || (in_instr == 32'h0010_0073));
          3'b100:  bad_s = 1'b1;
          default: bad_s = 1'b0;
        endcase
      end
`else
      OP_SYS: begin
        bad_s = 1'b1;
      end
`endif
      default: begin
        bad_s = 1'b1;
      end
    endcase

    if (bad_s || (in_instr[1:0] != 2'b11)) begin
      dec_s         = '0;
      dec_s.pc      = in_pc;
      dec_s.opcode  = op_s;
      dec_s.fmt     = FMT_BAD;
      dec_s.illegal = 1'b1;
    end else begin
      dec_s        = fld_s;
      dec_s.rd_wen = wr_s && (fld_s.rd != 5'd0);
    end
  end

  assign out_free_s = !out_valid_r || out_ready;
  assign in_ready   = (SKID != 32'd0) ? !skid_valid_r : out_free_s;
  assign accept_s   = in_valid && in_ready;

  // Output register plus skid entry; the skid only fills when the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
      out_r        <= '0;
      skid_r       <= '0;
    end else if (flush) begin
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (out_free_s) begin
      if (skid_valid_r) begin
        out_r        <= skid_r;
        out_valid_r  <= 1'b1;
        skid_valid_r <= 1'b0;
      end else begin
        out_valid_r <= accept_s;
        if (accept_s) begin
          out_r <= dec_s;
        end
      end
    end else if (accept_s) begin
      skid_r       <= dec_s;
      skid_valid_r <= 1'b1;
    end
  end

  assign out_valid   = out_valid_r;
  assign out_pc      = out_r.pc;
  assign out_opcode  = out_r.opcode;
  assign out_funct3  = out_r.funct3;
  assign out_funct7  = out_r.funct7;
  assign out_rs1     = out_r.rs1;
  assign out_rs2     = out_r.rs2;
  assign out_rd      = out_r.rd;
  assign out_rs1_en  = out_r.rs1_en;
  assign out_rs2_en  = out_r.rs2_en;
  assign out_rd_wen  = out_r.rd_wen;
  assign out_imm     = out_r.imm;
  assign out_fmt     = out_r.fmt;
  assign out_illegal = out_r.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed, table-driven bench for decode_stage: an RV32 single-register instance and an RV64 skid instance.
module tb_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        a_in_ready, a_valid, a_rs1_en, a_rs2_en, a_rd_wen, a_ill;
  logic [31:0] a_pc, a_imm;
  logic [6:0]  a_opc, a_f7;
  logic [2:0]  a_f3, a_fmt;
  logic [4:0]  a_rs1, a_rs2, a_rd;

  logic        b_in_ready, b_valid, b_rs1_en, b_rs2_en, b_rd_wen, b_ill;
  logic [63:0] b_pc, b_imm;
  logic [6:0]  b_opc, b_f7;
  logic [2:0]  b_f3, b_fmt;
  logic [4:0]  b_rs1, b_rs2, b_rd;

  decode_stage #(.XLEN(32), .SKID(0)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(a_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_opcode(a_opc), .out_funct3(a_f3), .out_funct7(a_f7),
    .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd), .out_rs1_en(a_rs1_en),
    .out_rs2_en(a_rs2_en), .out_rd_wen(a_rd_wen), .out_imm(a_imm), .out_fmt(a_fmt),
    .out_illegal(a_ill)
  );

  decode_stage #(.XLEN(64), .SKID(1)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_valid), .out_ready(out_ready),
    .out_pc(b_pc), .out_opcode(b_opc), .out_funct3(b_f3), .out_funct7(b_f7),
    .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd), .out_rs1_en(b_rs1_en),
    .out_rs2_en(b_rs2_en), .out_rd_wen(b_rd_wen), .out_imm(b_imm), .out_fmt(b_fmt),
    .out_illegal(b_ill)
  );

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  en;     // {rs1_en, rs2_en, rd_wen}
    logic [63:0] imm;    // RV64 value; RV32 expects the low word
    logic        ill32, ill64;
  } vec_t;

  vec_t vecs[$];
  int passed = 0;
  int total  = 0;

  function automatic vec_t mk(input logic [31:0] instr, input logic [2:0] fmt, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic [2:0] en, input logic [63:0] imm,
                              input logic ill32, input logic ill64);
    vec_t v;
    v.instr = instr; v.fmt = fmt; v.f3 = f3; v.f7 = f7; v.rs1 = rs1; v.rs2 = rs2;
    v.rd = rd; v.en = en; v.imm = imm; v.ill32 = ill32; v.ill64 = ill64;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_out(input string tag, input bit is64, input vec_t v, input logic [63:0] pc_e,
                         input logic valid, input logic [2:0] fmt, input logic ill,
                         input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [2:0] en, input logic [63:0] imm, input logic [63:0] pc);
    logic        e_ill;
    vec_t        e;
    logic [63:0] e_imm;
    e_ill = is64 ? v.ill64 : v.ill32;
    e = v;
    if (e_ill) begin
      e.fmt = 3'd7; e.f3 = 3'd0; e.f7 = 7'd0; e.rs1 = 5'd0; e.rs2 = 5'd0; e.rd = 5'd0;
      e.en = 3'd0; e.imm = 64'd0;
    end
    e_imm = is64 ? e.imm : {32'h0, e.imm[31:0]};
    chk($sformatf("%s %h valid", tag, v.instr), {63'd0, valid}, 64'd1);
    chk($sformatf("%s %h illegal", tag, v.instr), {63'd0, ill}, {63'd0, e_ill});
    chk($sformatf("%s %h fmt", tag, v.instr), {61'd0, fmt}, {61'd0, e.fmt});
    chk($sformatf("%s %h opcode", tag, v.instr), {57'd0, opc}, {57'd0, v.instr[6:0]});
    chk($sformatf("%s %h funct3", tag, v.instr), {61'd0, f3}, {61'd0, e.f3});
    chk($sformatf("%s %h funct7", tag, v.instr), {57'd0, f7}, {57'd0, e.f7});
    chk($sformatf("%s %h regs", tag, v.instr), {49'd0, rs1, rs2, rd}, {49'd0, e.rs1, e.rs2, e.rd});
    chk($sformatf("%s %h enables", tag, v.instr), {61'd0, en}, {61'd0, e.en});
    chk($sformatf("%s %h imm", tag, v.instr), imm, e_imm);
    chk($sformatf("%s %h pc", tag, v.instr), pc, is64 ? pc_e : {32'h0, pc_e[31:0]});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs.push_back(mk(32'h00400293, 3'd1, 3'd0, 7'h00, 5'd0,  5'd0,  5'd5,  3'b101, 64'd4, 1'b0, 1'b0));
    vecs.push_back(mk(32'h00B2A423, 3'd2, 3'd2, 7'h00, 5'd5,  5'd11, 5'd0,  3'b110, 64'd8, 1'b0, 1'b0));
    vecs.push_back(mk(32'hFE000EE3, 3'd3, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  3'b110, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0));
    vecs.push_back(mk(32'hAFDB55B7, 3'd4, 3'd0, 7'h00, 5'd0,  5'd0,  5'd11, 3'b001, 64'hFFFF_FFFF_AFDB_5000, 1'b0, 1'b0));
    vecs.push_back(mk(32'h00000000, 3'd7, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  3'b000, 64'd0, 1'b1, 1'b1));
    vecs.push_back(mk(32'h4000F033, 3'd7, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  3'b000, 64'd0, 1'b1, 1'b1));
    vecs.push_back(mk(32'h402081B3, 3'd0, 3'd0, 7'h20, 5'd1,  5'd2,  5'd3,  3'b111, 64'd0, 1'b0, 1'b0));
    vecs.push_back(mk(32'h40335293, 3'd1, 3'd5, 7'h20, 5'd6,  5'd0,  5'd5,  3'b101, 64'd3, 1'b0, 1'b0));
    vecs.push_back(mk(32'h02009093, 3'd1, 3'd1, 7'h00, 5'd1,  5'd0,  5'd1,  3'b101, 64'd32, 1'b1, 1'b0));
    vecs.push_back(mk(32'h0101B103, 3'd1, 3'd3, 7'h00, 5'd3,  5'd0,  5'd2,  3'b101, 64'd16, 1'b1, 1'b0));
    vecs.push_back(mk(32'hFFF02203, 3'd1, 3'd2, 7'h00, 5'd0,  5'd0,  5'd4,  3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0));
    vecs.push_back(mk(32'h001000EF, 3'd5, 3'd0, 7'h00, 5'd0,  5'd0,  5'd1,  3'b001, 64'h800, 1'b0, 1'b0));
    vecs.push_back(mk(32'h000090E7, 3'd7, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  3'b000, 64'd0, 1'b1, 1'b1));
    vecs.push_back(mk(32'h00002063, 3'd7, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  3'b000, 64'd0, 1'b1, 1'b1));
    vecs.push_back(mk(32'h00113023, 3'd2, 3'd3, 7'h00, 5'd2,  5'd1,  5'd0,  3'b110, 64'd0, 1'b1, 1'b0));
`ifdef DECODE_CSR_EN
    vecs.push_back(mk(32'h300110F3, 3'd6, 3'd1, 7'h00, 5'd2,  5'd0,  5'd1,  3'b101, 64'h300, 1'b0, 1'b0));
`else
    vecs.push_back(mk(32'h300110F3, 3'd7, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  3'b000, 64'd0, 1'b1, 1'b1));
`endif
    vecs.push_back(mk(32'h80000397, 3'd4, 3'd0, 7'h00, 5'd0,  5'd0,  5'd7,  3'b001, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0));
    vecs.push_back(mk(32'h00400292, 3'd7, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  3'b000, 64'd0, 1'b1, 1'b1));
    vecs.push_back(mk(32'h00000013, 3'd1, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  3'b100, 64'd0, 1'b0, 1'b0));
    vecs.push_back(mk(32'h02000033, 3'd7, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  3'b000, 64'd0, 1'b1, 1'b1));
    vecs.push_back(mk(32'h20005013, 3'd7, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  3'b000, 64'd0, 1'b1, 1'b1));
    vecs.push_back(mk(32'h00007003, 3'd7, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  3'b000, 64'd0, 1'b1, 1'b1));

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = 32'h0; in_pc = 64'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset a_valid", {63'd0, a_valid}, 64'd0);
    chk("reset b_valid", {63'd0, b_valid}, 64'd0);
    chk("reset a_in_ready", {63'd0, a_in_ready}, 64'd1);
    chk("reset b_in_ready", {63'd0, b_in_ready}, 64'd1);
    chk("reset a_imm_fmt", {29'd0, a_imm, a_fmt}, 64'd0);
    chk("reset b_imm", b_imm, 64'd0);

    // Back-to-back table vectors, one per cycle
    for (int i = 0; i < vecs.size(); i++) begin
      logic [63:0] pc_e;
      pc_e = {32'hC000_0000, 32'h0000_1000 + 32'(i * 4)};
      in_instr = vecs[i].instr; in_pc = pc_e; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk_out("rv32", 1'b0, vecs[i], pc_e, a_valid, a_fmt, a_ill, a_opc, a_f3, a_f7,
              a_rs1, a_rs2, a_rd, {a_rs1_en, a_rs2_en, a_rd_wen}, {32'h0, a_imm}, {32'h0, a_pc});
      chk_out("rv64", 1'b1, vecs[i], pc_e, b_valid, b_fmt, b_ill, b_opc, b_f3, b_f7,
              b_rs1, b_rs2, b_rd, {b_rs1_en, b_rs2_en, b_rd_wen}, b_imm, b_pc);
    end
    tick();
    chk("idle a_valid", {63'd0, a_valid}, 64'd0);
    chk("idle b_valid", {63'd0, b_valid}, 64'd0);

    // Output stability under backpressure, then combinational in_ready and mid-run reset
    out_ready = 1'b0; in_instr = 32'h00B2A423; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_instr = 32'h00400293;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("hold%0d a", k), {54'd0, a_valid, a_fmt, a_rs2, a_rd},
          {54'd0, 1'b1, 3'd2, 5'd11, 5'd0});
      chk($sformatf("hold%0d a_imm", k), {32'h0, a_imm}, 64'd8);
      chk($sformatf("hold%0d b", k), {54'd0, b_valid, b_fmt, b_rs2, b_rd},
          {54'd0, 1'b1, 3'd2, 5'd11, 5'd0});
      chk($sformatf("hold%0d b_imm", k), b_imm, 64'd8);
      if (k < 3) tick();
    end
    chk("stall a_in_ready", {63'd0, a_in_ready}, 64'd0);
    out_ready = 1'b1;
    #1;
    chk("comb a_in_ready", {63'd0, a_in_ready}, 64'd1);
    out_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2 a", {31'd0, a_valid, a_imm}, 64'd0);
    chk("rst2 b", {49'd0, b_valid, b_fmt, b_rs2, b_rs1, 1'b0}, 64'd0);
    chk("rst2 b_imm", b_imm, 64'd0);

    // Skid fill and drain on the RV64 instance
    in_valid = 1'b1; in_instr = 32'h00400293;
    tick();
    in_instr = 32'h00B2A423;
    tick();
    in_valid = 1'b0;
    chk("skid full b_in_ready", {63'd0, b_in_ready}, 64'd0);
    chk("skid head", {60'd0, b_valid, b_fmt}, {60'd0, 1'b1, 3'd1});
    chk("skid head imm", b_imm, 64'd4);
    out_ready = 1'b1;
    tick();
    chk("drain second", {55'd0, b_valid, b_fmt, b_rs2}, {55'd0, 1'b1, 3'd2, 5'd11});
    chk("drain imm", b_imm, 64'd8);
    chk("drain b_in_ready", {63'd0, b_in_ready}, 64'd1);
    tick();
    chk("drain empty", {63'd0, b_valid}, 64'd0);

    // Flush while the skid is full; the third word must never appear
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00400293;
    tick();
    in_instr = 32'h00B2A423;
    tick();
    chk("flush pre b_in_ready", {63'd0, b_in_ready}, 64'd0);
    in_instr = 32'hAFDB55B7; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush b_valid", {63'd0, b_valid}, 64'd0);
    chk("flush a_valid", {63'd0, a_valid}, 64'd0);
    chk("flush b_in_ready", {63'd0, b_in_ready}, 64'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("post flush%0d b_valid", k), {63'd0, b_valid}, 64'd0);
    end

    // Flush beats a simultaneous acceptance on both instances
    in_valid = 1'b1; in_instr = 32'hAFDB55B7; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush accept a_valid", {63'd0, a_valid}, 64'd0);
    chk("flush accept b_valid", {63'd0, b_valid}, 64'd0);
    tick();
    chk("flush after a_valid", {63'd0, a_valid}, 64'd0);
    chk("flush after b_valid", {63'd0, b_valid}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
